// File: rtl/controlador_de_entrada_pkg.sv
// rtl/controlador_de_entrada_pkg.sv - shared types and constants for the input controller
package pkg_entrada;

  typedef enum logic [2:0] {
    OCIOSO,
    ARMANDO,
    ESPERA_PRESS,
    ESPERA_SOLTA,
    PRONTO,
    FIM
  } estado_entrada_t;

  // Raw and debounced button level when nobody is pressing it (button is active-low)
  localparam logic BOTAO_SOLTO = 1'b1;

  localparam int LARGURA_DADO = 32;

  // States in which the block is waiting on the user (drives the board LED)
  function automatic logic estado_aguardando(estado_entrada_t e);
    return (e == ARMANDO) || (e == ESPERA_PRESS) || (e == ESPERA_SOLTA);
  endfunction

endpackage

// File: rtl/controlador_de_entrada_if.sv
// rtl/controlador_de_entrada_if.sv - board pins and control-unit handshake of the input controller
interface controlador_de_entrada_if
  import pkg_entrada::*;
#(
  parameter int LARGURA_CHAVES = 16
);

  logic                      isInsert;
  logic                      botao;
  logic [LARGURA_CHAVES-1:0] chaves;
  logic [LARGURA_DADO-1:0]   dadoEntrada;
  logic                      pronto;
  logic                      aguardando;

  // Side that drives the request and the board pins
  modport master (
    output isInsert,
    output botao,
    output chaves,
    input  dadoEntrada,
    input  pronto,
    input  aguardando
  );

  // The input controller itself
  modport slave (
    input  isInsert,
    input  botao,
    input  chaves,
    output dadoEntrada,
    output pronto,
    output aguardando
  );

endinterface

// File: rtl/controlador_de_entrada_debouncer.sv
// rtl/controlador_de_entrada_debouncer.sv - synchronised, debounced pushbutton with press/release pulses
module debouncer
  import pkg_entrada::*;
#(
  parameter int DEBOUNCE_CICLOS = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic botao,
  output logic estavel,
  output logic press,
  output logic solta
);

  localparam int W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [W-1:0] CONT_MAX = W'(DEBOUNCE_CICLOS - 1);

  logic         sinc1_q, sinc1_d;
  logic         sinc2_q, sinc2_d;
  logic         estavel_q, estavel_d;
  logic [W-1:0] cont_q, cont_d;
  logic         press_q, press_d;
  logic         solta_q, solta_d;

  // Two-flop synchroniser, then accept a new level only after it held for DEBOUNCE_CICLOS cycles
  always_comb begin
    sinc1_d   = botao;
    sinc2_d   = sinc1_q;
    estavel_d = estavel_q;
    cont_d    = cont_q;
    if (sinc2_q == estavel_q) begin
      cont_d = '0;
    end else if (cont_q == CONT_MAX) begin
      estavel_d = sinc2_q;
      cont_d    = '0;
    end else begin
      cont_d = cont_q + 1'b1;
    end
    press_d = estavel_q & ~estavel_d;
    solta_d = ~estavel_q & estavel_d;
  end

  // Synchroniser starts released so reset never looks like a press
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1_q   <= BOTAO_SOLTO;
      sinc2_q   <= BOTAO_SOLTO;
      estavel_q <= BOTAO_SOLTO;
      cont_q    <= '0;
      press_q   <= 1'b0;
      solta_q   <= 1'b0;
    end else begin
      sinc1_q   <= sinc1_d;
      sinc2_q   <= sinc2_d;
      estavel_q <= estavel_d;
      cont_q    <= cont_d;
      press_q   <= press_d;
      solta_q   <= solta_d;
    end
  end

  assign estavel = estavel_q;
  assign press   = press_q;
  assign solta   = solta_q;

endmodule

// File: rtl/controlador_de_entrada.sv
// rtl/controlador_de_entrada.sv - answers isInsert stalls with a debounced press/release and latched switches
module controlador_de_entrada
  import pkg_entrada::*;
#(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int LARGURA_CHAVES  = 16
) (
  input logic                     clock,
  input logic                     reset,
  controlador_de_entrada_if.slave bus
);

  logic                      estavel;
  logic                      press;
  logic                      solta;

  logic [LARGURA_CHAVES-1:0] chaves1_q, chaves1_d;
  logic [LARGURA_CHAVES-1:0] chaves2_q, chaves2_d;
  estado_entrada_t           estado_q, estado_d;
  logic [LARGURA_DADO-1:0]   dado_q, dado_d;
  logic                      pronto_q, pronto_d;
  logic                      aguardando_q, aguardando_d;

  debouncer #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_debouncer (
    .clock  (clock),
    .reset  (reset),
    .botao  (bus.botao),
    .estavel(estavel),
    .press  (press),
    .solta  (solta)
  );

  // Next state; a dropped request always wins over a button event while waiting on the user
  always_comb begin
    chaves1_d = bus.chaves;
    chaves2_d = chaves1_q;
    estado_d  = estado_q;
    dado_d    = dado_q;
    case (estado_q)
      OCIOSO: begin
        if (bus.isInsert) estado_d = ARMANDO;
      end
      ARMANDO: begin
        if (!bus.isInsert)              estado_d = OCIOSO;
        else if (estavel == BOTAO_SOLTO) estado_d = ESPERA_PRESS;
      end
      ESPERA_PRESS: begin
        if (!bus.isInsert) begin
          estado_d = OCIOSO;
        end else if (press) begin
          dado_d   = LARGURA_DADO'(chaves2_q);
          estado_d = ESPERA_SOLTA;
        end
      end
      ESPERA_SOLTA: begin
        if (!bus.isInsert) estado_d = OCIOSO;
        else if (solta)    estado_d = PRONTO;
      end
      PRONTO: begin
        estado_d = FIM;
      end
      FIM: begin
        if (!bus.isInsert) estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
    pronto_d     = (estado_d == PRONTO);
    aguardando_d = estado_aguardando(estado_d);
  end

  // State, registered outputs and switch synchroniser
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chaves1_q    <= '0;
      chaves2_q    <= '0;
      estado_q     <= OCIOSO;
      dado_q       <= '0;
      pronto_q     <= 1'b0;
      aguardando_q <= 1'b0;
    end else begin
      chaves1_q    <= chaves1_d;
      chaves2_q    <= chaves2_d;
      estado_q     <= estado_d;
      dado_q       <= dado_d;
      pronto_q     <= pronto_d;
      aguardando_q <= aguardando_d;
    end
  end

  assign bus.dadoEntrada = dado_q;
  assign bus.pronto      = pronto_q;
  assign bus.aguardando  = aguardando_q;

endmodule

// File: tb/tb_controlador_de_entrada.sv
// tb/tb_controlador_de_entrada.sv - self-checking bench for controlador_de_entrada
module tb_controlador_de_entrada;

  localparam int D = 4;
  // pin change -> pronto: 2 sync cycles, D stable cycles, one cycle from solta to PRONTO
  localparam int LAT_SOLTA_PRONTO = 2 + D + 1;
  // pin press -> press pulse visible
  localparam int LAT_PRESS = 2 + D;

  logic clk = 1'b0;
  logic rst = 1'b1;

  controlador_de_entrada_if #(.LARGURA_CHAVES(16)) bus ();

  controlador_de_entrada #(
    .DEBOUNCE_CICLOS(D),
    .LARGURA_CHAVES (16)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          n_pronto = 0;
  int          n_press = 0;
  int          n_double = 0;
  int          pronto_cyc = 0;
  logic [31:0] dado_pronto = '0;
  logic        prev_pronto = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe pulses a moment after each edge
  always @(posedge clk) begin
    #1;
    if (bus.pronto === 1'b1) begin
      n_pronto++;
      pronto_cyc  = cyc;
      dado_pronto = bus.dadoEntrada;
      if (prev_pronto) n_double++;
    end
    if (dut.u_debouncer.press === 1'b1) n_press++;
    prev_pronto = (bus.pronto === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_release(input logic [15:0] chv, input int hold, output int rel_cyc);
    bus.chaves = chv;
    bus.botao  = 1'b0;
    step(hold);
    bus.chaves = 16'($urandom);
    bus.botao  = 1'b1;
    rel_cyc    = cyc;
    step(LAT_SOLTA_PRONTO + 5);
  endtask

  task automatic test_reset;
    bus.isInsert = 1'b0;
    bus.botao    = 1'b1;
    bus.chaves   = '0;
    rst          = 1'b1;
    step(2);
    checks++;
    if (bus.pronto !== 1'b0 || bus.aguardando !== 1'b0 || bus.dadoEntrada !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: pronto=%b aguardando=%b dado=%h, required 0 0 00000000",
               bus.pronto, bus.aguardando, bus.dadoEntrada);
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_basic;
    int n0, rel;
    n0 = n_pronto;
    bus.chaves   = 16'hA5C3;
    bus.isInsert = 1'b1;
    step(1);
    checks++;
    if (bus.aguardando !== 1'b1) begin
      errors++;
      $display("FAIL basic_aguardando_on: got %b required 1", bus.aguardando);
    end
    step(2);
    press_release(16'hA5C3, 10, rel);
    checks++;
    if (n_pronto - n0 != 1) begin
      errors++;
      $display("FAIL basic_pronto_count: got %0d required 1", n_pronto - n0);
    end
    checks++;
    if (dado_pronto !== 32'h0000A5C3) begin
      errors++;
      $display("FAIL basic_dado: got %h required 0000a5c3", dado_pronto);
    end
    checks++;
    if (pronto_cyc - rel != LAT_SOLTA_PRONTO) begin
      errors++;
      $display("FAIL basic_latency: got %0d required %0d", pronto_cyc - rel, LAT_SOLTA_PRONTO);
    end
    checks++;
    if (bus.aguardando !== 1'b0) begin
      errors++;
      $display("FAIL basic_aguardando_off: got %b required 0", bus.aguardando);
    end
    bus.isInsert = 1'b0;
    step(2);
  endtask

  task automatic test_bounce;
    int n0, p0, rel;
    logic [31:0] exp_dado;
    n0 = n_pronto;
    p0 = n_press;
    exp_dado = bus.dadoEntrada;
    bus.isInsert = 1'b1;
    step(3);
    for (int i = 0; i < 10; i++) begin
      bus.botao = ~bus.botao;
      step(2);
    end
    bus.botao = 1'b1;
    step(D + 4);
    checks++;
    if (n_press != p0 || bus.dadoEntrada !== exp_dado || bus.aguardando !== 1'b1) begin
      errors++;
      $display("FAIL bounce_rejected: presses=%0d dado=%h aguardando=%b required 0 %h 1",
               n_press - p0, bus.dadoEntrada, bus.aguardando, exp_dado);
    end
    press_release(16'h3C5A, 10, rel);
    checks++;
    if (n_pronto - n0 != 1 || dado_pronto !== 32'h00003C5A) begin
      errors++;
      $display("FAIL bounce_capture: prontos=%0d dado=%h required 1 00003c5a", n_pronto - n0, dado_pronto);
    end
    bus.isInsert = 1'b0;
    step(2);
  endtask

  task automatic test_preheld;
    int n0, rel;
    n0 = n_pronto;
    bus.chaves = 16'h1111;
    bus.botao  = 1'b0;
    step(LAT_PRESS + 2);
    bus.isInsert = 1'b1;
    step(12);
    bus.botao = 1'b1;
    step(LAT_SOLTA_PRONTO + 5);
    checks++;
    if (n_pronto != n0 || bus.aguardando !== 1'b1) begin
      errors++;
      $display("FAIL preheld_first_ignored: prontos=%0d aguardando=%b required 0 1", n_pronto - n0, bus.aguardando);
    end
    press_release(16'h2222, 11, rel);
    checks++;
    if (n_pronto - n0 != 1 || dado_pronto !== 32'h00002222) begin
      errors++;
      $display("FAIL preheld_second: prontos=%0d dado=%h required 1 00002222", n_pronto - n0, dado_pronto);
    end
    bus.isInsert = 1'b0;
    step(2);
  endtask

  task automatic test_abort;
    int n0;
    n0 = n_pronto;
    bus.isInsert = 1'b1;
    step(3);
    bus.chaves = 16'h7E01;
    bus.botao  = 1'b0;
    step(10);
    bus.isInsert = 1'b0;
    step(1);
    checks++;
    if (bus.aguardando !== 1'b0 || bus.dadoEntrada !== 32'h00007E01) begin
      errors++;
      $display("FAIL abort_solta: aguardando=%b dado=%h required 0 00007e01", bus.aguardando, bus.dadoEntrada);
    end
    bus.botao = 1'b1;
    step(LAT_SOLTA_PRONTO + 5);
    checks++;
    if (n_pronto != n0) begin
      errors++;
      $display("FAIL abort_no_pronto: got %0d required 0", n_pronto - n0);
    end
    // Request drops in the very cycle the press is recognised
    bus.isInsert = 1'b1;
    step(3);
    bus.chaves = 16'hBEEF;
    bus.botao  = 1'b0;
    step(LAT_PRESS);
    checks++;
    if (dut.u_debouncer.press !== 1'b1) begin
      errors++;
      $display("FAIL abort_press_alignment: press=%b required 1", dut.u_debouncer.press);
    end
    bus.isInsert = 1'b0;
    step(1);
    checks++;
    if (bus.dadoEntrada !== 32'h00007E01 || bus.aguardando !== 1'b0) begin
      errors++;
      $display("FAIL abort_simultaneous: dado=%h aguardando=%b required 00007e01 0", bus.dadoEntrada, bus.aguardando);
    end
    bus.botao = 1'b1;
    step(LAT_SOLTA_PRONTO + 5);
  endtask

  task automatic test_held_request;
    int n0, rel;
    n0 = n_pronto;
    bus.isInsert = 1'b1;
    step(3);
    press_release(16'h0F0F, 10, rel);
    step(5);
    checks++;
    if (n_pronto - n0 != 1) begin
      errors++;
      $display("FAIL held_single_pronto: got %0d required 1", n_pronto - n0);
    end
    bus.isInsert = 1'b0;
    step(1);
    bus.isInsert = 1'b1;
    step(LAT_SOLTA_PRONTO + 3);
    checks++;
    if (n_pronto - n0 != 1 || bus.aguardando !== 1'b1) begin
      errors++;
      $display("FAIL held_rearm: prontos=%0d aguardando=%b required 1 1", n_pronto - n0, bus.aguardando);
    end
    press_release(16'hF0F0, 12, rel);
    checks++;
    if (n_pronto - n0 != 2 || dado_pronto !== 32'h0000F0F0) begin
      errors++;
      $display("FAIL held_second: prontos=%0d dado=%h required 2 0000f0f0", n_pronto - n0, dado_pronto);
    end
    bus.isInsert = 1'b0;
    step(2);
  endtask

  task automatic test_reset_mid_wait;
    int n0, rel;
    bus.isInsert = 1'b1;
    step(3);
    bus.chaves = 16'h5555;
    bus.botao  = 1'b0;
    step(3);
    n0 = n_pronto;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pronto !== 1'b0 || bus.aguardando !== 1'b0 || bus.dadoEntrada !== 32'h0 ||
        dut.u_debouncer.estavel !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wait: pronto=%b aguardando=%b dado=%h estavel=%b required 0 0 00000000 1",
               bus.pronto, bus.aguardando, bus.dadoEntrada, dut.u_debouncer.estavel);
    end
    @(negedge clk);
    bus.botao = 1'b1;
    rst       = 1'b0;
    step(1);
    checks++;
    if (bus.aguardando !== 1'b1 || n_pronto != n0) begin
      errors++;
      $display("FAIL reset_restart: aguardando=%b prontos=%0d required 1 0", bus.aguardando, n_pronto - n0);
    end
    step(2);
    press_release(16'h9876, 10, rel);
    checks++;
    if (n_pronto - n0 != 1 || dado_pronto !== 32'h00009876) begin
      errors++;
      $display("FAIL reset_recapture: prontos=%0d dado=%h required 1 00009876", n_pronto - n0, dado_pronto);
    end
    bus.isInsert = 1'b0;
    step(2);
  endtask

  // Random transactions: glitchy lead-in, then a clean press/release with random switches
  task automatic test_random;
    int n0, p0, rel, hold;
    logic [15:0] v;
    for (int t = 0; t < 6; t++) begin
      n0 = n_pronto;
      v  = 16'($urandom);
      bus.isInsert = 1'b1;
      step(3);
      p0 = n_press;
      for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
        bus.botao = 1'b0;
        step($urandom_range(1, D - 1));
        bus.botao = 1'b1;
        step($urandom_range(1, 3));
      end
      step(D + 2);
      checks++;
      if (n_press != p0) begin
        errors++;
        $display("FAIL random_glitch_%0d: presses=%0d required 0", t, n_press - p0);
      end
      hold = $urandom_range(10, 16);
      press_release(v, hold, rel);
      checks++;
      if (n_pronto - n0 != 1 || dado_pronto !== {16'h0, v} || pronto_cyc - rel != LAT_SOLTA_PRONTO) begin
        errors++;
        $display("FAIL random_capture_%0d: prontos=%0d dado=%h lat=%0d required 1 %h %0d",
                 t, n_pronto - n0, dado_pronto, pronto_cyc - rel, {16'h0, v}, LAT_SOLTA_PRONTO);
      end
      bus.isInsert = 1'b0;
      step($urandom_range(1, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_preheld();
    test_abort();
    test_held_request();
    test_reset_mid_wait();
    test_random();
    checks++;
    if (n_double != 0) begin
      errors++;
      $display("FAIL pronto_width: multi-cycle pulses=%0d required 0", n_double);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_de_entrada.md
# controlador_de_entrada

Responder side of the control unit's `isInsert` stall request. While the processor is parked on an `in`, `ckhd`, `ckim` or `ckdm` instruction with `isInput` set, this block does the following:
- debounces the board confirm pushbutton;
- waits for one full press-and-release;
- latches the switch value;
- returns a one-cycle `pronto` pulse so the datapath can take `dadoEntrada` and advance PC.

It sits between the board I/O pins and the control unit/datapath, in the same clock domain as the CPU.

## Interface
Parameters:
- `DEBOUNCE_CICLOS`, default 500000: stable-level cycles required to accept a button level change (10 ms at 50 MHz).
- `LARGURA_CHAVES`, default 16: number of board switches.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; the control unit's `reset` output drives it directly.
- `isInsert`  in  1  stall request from the control unit. Level signal, held until the instruction retires.
- `botao`  in  1  raw confirm pushbutton, active-low (0 = pressed), asynchronous to `clock`.
- `chaves`  in  LARGURA_CHAVES  raw switch levels, asynchronous.
- `dadoEntrada`  out  32  latched switch value, zero-extended. Held until the next capture.
- `pronto`  out  1  one-cycle pulse: input accepted, stall may be released.
- `aguardando`  out  1  high while the block waits for the user. Drives the board LED.

## Operation
Input synchronisation:
- `botao` and `chaves` each pass through a 2-flop synchroniser.
- `botao` sync flops reset to 1; `chaves` sync flops reset to 0.

Debouncer:
- `estavel` resets to 1 (released).
- The counter clears whenever the synced button level equals `estavel`.
- Otherwise the counter increments. When it reaches `DEBOUNCE_CICLOS-1`, `estavel` takes the synced level and the counter clears.
- Counter width is `$clog2(DEBOUNCE_CICLOS)`; it never wraps.
- `press` = one-cycle pulse on an `estavel` 1→0 transition. `solta` = one-cycle pulse on an `estavel` 0→1 transition.

State machine (resets to OCIOSO):
- OCIOSO: `isInsert`=1 → ARMANDO.
- ARMANDO: `estavel`=1 → ESPERA_PRESS. This rejects a button already held when the request arrived.
- ESPERA_PRESS: on `press`, latch the synced `chaves` into `dadoEntrada` (zero-extended) → ESPERA_SOLTA.
- ESPERA_SOLTA: on `solta` → PRONTO.
- PRONTO: `pronto`=1 for exactly this cycle → FIM.
- FIM: `isInsert`=0 → OCIOSO. This blocks re-triggering on the same instruction if the control unit holds `isInsert` an extra cycle.

Abort rule:
- In ARMANDO, ESPERA_PRESS or ESPERA_SOLTA, if `isInsert` drops, go to OCIOSO.
- No `pronto` is issued; `dadoEntrada` keeps whatever was latched.

Outputs:
- `aguardando` = state ∈ {ARMANDO, ESPERA_PRESS, ESPERA_SOLTA}.
- `pronto` is registered, as is `dadoEntrada`.

Reset behaviour:
- Reset values: `dadoEntrada`=0, `pronto`=0, `aguardando`=0.
- Reset asserted mid-operation returns to OCIOSO immediately (asynchronous). No `pronto` is emitted afterwards.

## Timing
- Raw pin → synced level: 2 cycles.
- Synced level change → `estavel` update: `DEBOUNCE_CICLOS` cycles of uninterrupted stable level.
- `isInsert` rise → ARMANDO: 1 cycle. ARMANDO → ESPERA_PRESS: 1 cycle if the button is already released.
- `solta` → `pronto` high: 1 cycle (ESPERA_SOLTA → PRONTO edge).
- `pronto` high for exactly 1 cycle per accepted press.
- `dadoEntrada` is valid from the cycle after `press` and is stable while `pronto`=1.
- The datapath samples `dadoEntrada` in the `pronto` cycle.
- Glitch rejection: bounce shorter than `DEBOUNCE_CICLOS` cycles produces neither `press` nor `solta`.
- Simultaneous events: if `isInsert` falls in the same cycle as `press`, the abort wins. `dadoEntrada` is not updated.

## Structure
- Shared package `pkg_entrada`:
  - state enum `estado_entrada_t` (OCIOSO, ARMANDO, ESPERA_PRESS, ESPERA_SOLTA, PRONTO, FIM);
  - constant `BOTAO_SOLTO = 1'b1`.
- One natural sub-module: `debouncer`. Parameter `DEBOUNCE_CICLOS`; contains the synchroniser, counter and `estavel`; outputs `press` and `solta`.
- The control unit reuses `debouncer` for any other board button.
- Switch synchronisers stay in the top module.
- Expected size: about 150–200 lines total.

## Test plan
All benches use `DEBOUNCE_CICLOS=4`.
- Basic capture:
  - Stimulus: `chaves`=16'hA5C3; `isInsert` high; clean press held 10 cycles, then released.
  - Response: `aguardando` high from cycle +1; `pronto` for 1 cycle; `dadoEntrada`=32'h0000A5C3; `aguardando` low.
- Bounce rejection:
  - Stimulus: `botao` toggles every 2 cycles for 20 cycles, then a stable press and release.
  - Response: exactly one `pronto`; no `press` pulse during the toggling.
- Pre-held button:
  - Stimulus: button pressed before `isInsert` rises; held 12 cycles; released; pressed again; released.
  - Response: `pronto` only after the second release. `dadoEntrada` holds the switch value at the second press.
- Abort:
  - Stimulus: `isInsert` falls while in ESPERA_SOLTA.
  - Response: OCIOSO; no `pronto`; `dadoEntrada` unchanged.
- Held request:
  - Stimulus: `isInsert` stays high 5 cycles after `pronto`, then falls; rises again.
  - Response: no second `pronto` until a new press and release.
- Reset mid-wait:
  - Stimulus: `reset` pulse in ESPERA_PRESS.
  - Response: all outputs 0 immediately; `estavel`=1; the state machine restarts from OCIOSO.
